// File: rtl/marmot_sram_reader_pkg.sv
// Shared definitions for the Wishbone read port onto the cache SRAM macros.
// Region codes follow wbs_adr_i[15:14].
package marmot_sram_reader_pkg;

  localparam logic [1:0] REG_D32 = 2'd0;
  localparam logic [1:0] REG_TAG = 2'd1;
  localparam logic [1:0] REG_D64 = 2'd2;
  localparam logic [1:0] REG_ID  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ACK
  } state_t;

  localparam int D32_BANKS = 4;
  localparam int TAG_BANKS = 2;
  localparam int D64_BANKS = 4;

  localparam int D32_IDX_W = 9;
  localparam int TAG_IDX_W = 8;
  localparam int D64_IDX_W = 9;

endpackage

// File: rtl/marmot_sram_rd_mux.sv
// Read-data select across all port-1 SRAM outputs by region, bank and 64-bit half.
// Purely combinational; its output is captured by the top module.
module marmot_sram_rd_mux
  import marmot_sram_reader_pkg::*;
(
  input  logic [1:0]  region,
  input  logic [1:0]  bank,
  input  logic        half,
  input  logic [31:0] d32_rdata0,
  input  logic [31:0] d32_rdata1,
  input  logic [31:0] d32_rdata2,
  input  logic [31:0] d32_rdata3,
  input  logic [31:0] tag_rdata0,
  input  logic [31:0] tag_rdata1,
  input  logic [63:0] d64_rdata0,
  input  logic [63:0] d64_rdata1,
  input  logic [63:0] d64_rdata2,
  input  logic [63:0] d64_rdata3,
  output logic [31:0] rdata
);

  logic [63:0] d64_word;
  logic [31:0] d32_word;

  always_comb begin
    d64_word = '0;
    d32_word = '0;
    rdata    = '0;
    case (bank)
      2'd0: begin d64_word = d64_rdata0; d32_word = d32_rdata0; end
      2'd1: begin d64_word = d64_rdata1; d32_word = d32_rdata1; end
      2'd2: begin d64_word = d64_rdata2; d32_word = d32_rdata2; end
      default: begin d64_word = d64_rdata3; d32_word = d32_rdata3; end
    endcase
    case (region)
      REG_D32: rdata = d32_word;
      REG_TAG: rdata = bank[0] ? tag_rdata1 : tag_rdata0;
      REG_D64: rdata = half ? d64_word[63:32] : d64_word[31:0];
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/marmot_sram_reader.sv
// Wishbone read-only window onto port 1 of every cache SRAM; writes are acked and dropped.
// SRAM reads ack in cycle 2+RD_LAT, everything else in cycle 1; dropping cyc mid-read suppresses the ack.
module marmot_sram_reader
  import marmot_sram_reader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] ID_WORD   = 32'h4D52_4D54
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  output logic [D32_BANKS-1:0] d32_csb1,
  output logic [D32_IDX_W-1:0] d32_addr1,
  output logic [TAG_BANKS-1:0] tag_csb1,
  output logic [TAG_IDX_W-1:0] tag_addr1,
  output logic [D64_BANKS-1:0] d64_csb1,
  output logic [D64_IDX_W-1:0] d64_addr1,
  input  logic [31:0]          d32_rdata0,
  input  logic [31:0]          d32_rdata1,
  input  logic [31:0]          d32_rdata2,
  input  logic [31:0]          d32_rdata3,
  input  logic [31:0]          tag_rdata0,
  input  logic [31:0]          tag_rdata1,
  input  logic [63:0]          d64_rdata0,
  input  logic [63:0]          d64_rdata1,
  input  logic [63:0]          d64_rdata2,
  input  logic [63:0]          d64_rdata3
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  state_t      state;
  logic [1:0]  lat_cnt;
  logic        abort_q;
  logic [1:0]  region_q;
  logic [1:0]  bank_q;
  logic        half_q;
  logic [31:0] mux_rdata;

  logic        hit;
  logic [1:0]  region;
  logic [1:0]  bank_dec;
  logic        mapped;
  logic        unused_ok;

  assign unused_ok = ^{wbs_sel_i, wbs_dat_i, wbs_adr_i[1:0]};

  assign hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:16] == BASE_ADDR[31:16]);
  assign region = wbs_adr_i[15:14];

  always_comb begin
    bank_dec = '0;
    mapped   = 1'b0;
    case (region)
      REG_D32: begin bank_dec = wbs_adr_i[12:11];         mapped = ~wbs_adr_i[13]; end
      REG_TAG: begin bank_dec = {1'b0, wbs_adr_i[10]};    mapped = (wbs_adr_i[13:11] == 3'd0); end
      REG_D64: begin bank_dec = wbs_adr_i[13:12];         mapped = 1'b1; end
      default: begin bank_dec = '0;                       mapped = 1'b0; end
    endcase
  end

  marmot_sram_rd_mux u_mux (
    .region     (region_q),
    .bank       (bank_q),
    .half       (half_q),
    .d32_rdata0 (d32_rdata0),
    .d32_rdata1 (d32_rdata1),
    .d32_rdata2 (d32_rdata2),
    .d32_rdata3 (d32_rdata3),
    .tag_rdata0 (tag_rdata0),
    .tag_rdata1 (tag_rdata1),
    .d64_rdata0 (d64_rdata0),
    .d64_rdata1 (d64_rdata1),
    .d64_rdata2 (d64_rdata2),
    .d64_rdata3 (d64_rdata3),
    .rdata      (mux_rdata)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      lat_cnt   <= '0;
      abort_q   <= 1'b0;
      region_q  <= '0;
      bank_q    <= '0;
      half_q    <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      d32_csb1  <= '1;
      tag_csb1  <= '1;
      d64_csb1  <= '1;
      d32_addr1 <= '0;
      tag_addr1 <= '0;
      d64_addr1 <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          lat_cnt <= '0;
          abort_q <= 1'b0;
          if (hit) begin
            region_q <= region;
            bank_q   <= bank_dec;
            half_q   <= wbs_adr_i[2];
            if (!wbs_we_i && region != REG_ID && mapped) begin
              state <= ST_ISSUE;
              case (region)
                REG_D32: begin
                  d32_csb1  <= ~(4'b0001 << bank_dec);
                  d32_addr1 <= wbs_adr_i[10:2];
                end
                REG_TAG: begin
                  tag_csb1  <= ~(2'b01 << bank_dec[0]);
                  tag_addr1 <= wbs_adr_i[9:2];
                end
                default: begin
                  d64_csb1  <= ~(4'b0001 << bank_dec);
                  d64_addr1 <= wbs_adr_i[11:3];
                end
              endcase
            end else begin
              // Writes, ID reads and unmapped reads complete without touching the SRAMs.
              state     <= ST_ACK;
              wbs_ack_o <= 1'b1;
              wbs_dat_o <= (!wbs_we_i && region == REG_ID) ? ID_WORD : 32'h0;
            end
          end
        end
        ST_ISSUE: begin
          d32_csb1 <= '1;
          tag_csb1 <= '1;
          d64_csb1 <= '1;
          if (!wbs_cyc_i) abort_q <= 1'b1;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            // The SRAM access always runs to completion; only the response is dropped.
            if (abort_q || !wbs_cyc_i) begin
              state <= ST_IDLE;
            end else begin
              wbs_dat_o <= mux_rdata;
              wbs_ack_o <= 1'b1;
              state     <= ST_ACK;
            end
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
            if (!wbs_cyc_i) abort_q <= 1'b1;
          end
        end
        ST_ACK: begin
          wbs_ack_o <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
